// File: rtl/axi_r_buffer.sv
// AXI read-data channel buffer: DEPTH-entry FIFO with optional
// store-and-forward release on burst boundaries and occupancy status.
module axi_r_buffer #(
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int DEPTH     = 8,
    parameter int STORE_FWD = 0
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic [ID_W-1:0]          in_rid,
    input  logic [DATA_W-1:0]        in_rdata,
    input  logic [1:0]               in_rresp,
    input  logic                     in_rlast,
    input  logic                     in_rvalid,
    output logic                     in_rready,
    output logic [ID_W-1:0]          out_rid,
    output logic [DATA_W-1:0]        out_rdata,
    output logic [1:0]               out_rresp,
    output logic                     out_rlast,
    output logic                     out_rvalid,
    input  logic                     out_rready,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   bursts_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = ID_W + DATA_W + 3;

    typedef logic [AW:0] ptr_t;
    localparam ptr_t ONE = ptr_t'(1);

    logic [BW-1:0] mem_q [DEPTH];

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t count_q, count_d;
    ptr_t bursts_q, bursts_d;
    logic rel_q, rel_d;

    logic full, empty, push, pop, head_ok;
    logic last_in, last_out;

    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    assign in_rready = arstn_i && !full;
    assign push      = in_rvalid && in_rready;
    assign pop       = out_rvalid && out_rready;

    assign {out_rid, out_rdata, out_rresp, out_rlast} =
        mem_q[rptr_q[AW-1:0]];

    // Head is offered only once a whole burst is held, unless the
    // buffer is full or a forced release is already draining.
    always_comb begin
        head_ok = 1'b1;
        if (STORE_FWD != 0) begin
            head_ok = (bursts_q != '0) || full || rel_q;
        end
    end

    assign out_rvalid = !empty && head_ok;

    assign last_in  = push && in_rlast;
    assign last_out = pop && out_rlast;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        bursts_d = bursts_q;
        rel_d    = rel_q;
        if (push) begin
            wptr_d = wptr_q + ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + ONE;
        end
        if (push && !pop) begin
            count_d = count_q + ONE;
        end else if (pop && !push) begin
            count_d = count_q - ONE;
        end
        if (last_in && !last_out) begin
            bursts_d = bursts_q + ONE;
        end else if (last_out && !last_in) begin
            bursts_d = bursts_q - ONE;
        end
        if (empty || last_out) begin
            rel_d = 1'b0;
        end else if (pop && bursts_q == '0) begin
            rel_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            bursts_q <= '0;
            rel_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            bursts_q <= bursts_d;
            rel_q    <= rel_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {in_rid, in_rdata, in_rresp, in_rlast};
        end
    end

    assign count_o  = count_q;
    assign bursts_o = bursts_q;

endmodule

// File: tb/tb_axi_r_buffer.sv
// Directed bench for axi_r_buffer: cut-through DEPTH=8,
// store-and-forward DEPTH=8 and store-and-forward DEPTH=4.
module tb_axi_r_buffer;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [3:0]  a_in_rid, a_out_rid, b_in_rid, b_out_rid, c_in_rid, c_out_rid;
    logic [63:0] a_in_rdata, a_out_rdata, b_in_rdata, b_out_rdata;
    logic [63:0] c_in_rdata, c_out_rdata;
    logic [1:0]  a_in_rresp, a_out_rresp, b_in_rresp, b_out_rresp;
    logic [1:0]  c_in_rresp, c_out_rresp;
    logic a_in_rlast, a_in_rvalid, a_in_rready, a_out_rlast, a_out_rvalid, a_out_rready;
    logic b_in_rlast, b_in_rvalid, b_in_rready, b_out_rlast, b_out_rvalid, b_out_rready;
    logic c_in_rlast, c_in_rvalid, c_in_rready, c_out_rlast, c_out_rvalid, c_out_rready;
    logic [3:0] a_count, a_bursts, b_count, b_bursts;
    logic [2:0] c_count, c_bursts;

    axi_r_buffer #(.DATA_W(64), .ID_W(4), .DEPTH(8), .STORE_FWD(0)) u_a (
        .clk_i(clk), .arstn_i(arstn),
        .in_rid(a_in_rid), .in_rdata(a_in_rdata), .in_rresp(a_in_rresp),
        .in_rlast(a_in_rlast), .in_rvalid(a_in_rvalid), .in_rready(a_in_rready),
        .out_rid(a_out_rid), .out_rdata(a_out_rdata), .out_rresp(a_out_rresp),
        .out_rlast(a_out_rlast), .out_rvalid(a_out_rvalid), .out_rready(a_out_rready),
        .count_o(a_count), .bursts_o(a_bursts)
    );

    axi_r_buffer #(.DATA_W(64), .ID_W(4), .DEPTH(8), .STORE_FWD(1)) u_b (
        .clk_i(clk), .arstn_i(arstn),
        .in_rid(b_in_rid), .in_rdata(b_in_rdata), .in_rresp(b_in_rresp),
        .in_rlast(b_in_rlast), .in_rvalid(b_in_rvalid), .in_rready(b_in_rready),
        .out_rid(b_out_rid), .out_rdata(b_out_rdata), .out_rresp(b_out_rresp),
        .out_rlast(b_out_rlast), .out_rvalid(b_out_rvalid), .out_rready(b_out_rready),
        .count_o(b_count), .bursts_o(b_bursts)
    );

    axi_r_buffer #(.DATA_W(64), .ID_W(4), .DEPTH(4), .STORE_FWD(1)) u_c (
        .clk_i(clk), .arstn_i(arstn),
        .in_rid(c_in_rid), .in_rdata(c_in_rdata), .in_rresp(c_in_rresp),
        .in_rlast(c_in_rlast), .in_rvalid(c_in_rvalid), .in_rready(c_in_rready),
        .out_rid(c_out_rid), .out_rdata(c_out_rdata), .out_rresp(c_out_rresp),
        .out_rlast(c_out_rlast), .out_rvalid(c_out_rvalid), .out_rready(c_out_rready),
        .count_o(c_count), .bursts_o(c_bursts)
    );

    function automatic logic [63:0] pd(input int n);
        return 64'hC0DE_0000_0000_0000 | 64'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input int n, input logic last, input logic v);
        a_in_rid = 4'(n); a_in_rdata = pd(n); a_in_rresp = 2'(n);
        a_in_rlast = last; a_in_rvalid = v;
    endtask

    task automatic drv_b(input int n, input logic last, input logic v);
        b_in_rid = 4'(n); b_in_rdata = pd(n); b_in_rresp = 2'(n);
        b_in_rlast = last; b_in_rvalid = v;
    endtask

    task automatic drv_c(input int n, input logic last, input logic v);
        c_in_rid = 4'(n); c_in_rdata = pd(n); c_in_rresp = 2'(n);
        c_in_rlast = last; c_in_rvalid = v;
    endtask

    // Invariants: occupancy bounds, no push when full, no pop when empty,
    // and a presented beat on u_a holds until it is taken.
    logic pa_ok = 1'b0, pa_v = 1'b0, pa_r = 1'b0;
    logic [63:0] pa_d = '0;
    always @(negedge clk) begin
        if (arstn) begin
            if (a_count > 4'd8 || b_count > 4'd8 || c_count > 3'd4) begin
                fails++; $display("FAIL occupancy a=%0d b=%0d c=%0d", a_count, b_count, c_count);
            end
            if ((a_in_rready && a_count == 4'd8) || (c_in_rready && c_count == 3'd4)) begin
                fails++; $display("FAIL ready_when_full a=%0d c=%0d", a_count, c_count);
            end
            if ((a_out_rvalid && a_count == 0) || (c_out_rvalid && c_count == 0)) begin
                fails++; $display("FAIL valid_when_empty a=%b c=%b", a_out_rvalid, c_out_rvalid);
            end
            if (pa_ok && pa_v && !pa_r && (!a_out_rvalid || a_out_rdata !== pa_d)) begin
                fails++; $display("FAIL hold got v=%b d=%h want v=1 d=%h", a_out_rvalid, a_out_rdata, pa_d);
            end
        end
        pa_ok = arstn; pa_v = a_out_rvalid; pa_r = a_out_rready; pa_d = a_out_rdata;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        tick(); tick();
        tests++; if (a_in_rready !== 1'b0) begin fails++; $display("FAIL rst_rready got %b want 0", a_in_rready); end
        tests++; if (a_out_rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid got %b want 0", a_out_rvalid); end
        tests++; if (a_count !== 4'd0 || a_bursts !== 4'd0) begin fails++; $display("FAIL rst_counts got %0d/%0d want 0/0", a_count, a_bursts); end
        arstn = 1'b1;
        #1;
        tests++; if (a_in_rready !== 1'b1 || c_in_rready !== 1'b1) begin fails++; $display("FAIL rel_rready got %b%b want 11", a_in_rready, c_in_rready); end
    endtask

    task automatic test_single();
        a_in_rid = 4'd3; a_in_rdata = 64'hDEAD_BEEF; a_in_rresp = 2'd0;
        a_in_rlast = 1'b1; a_in_rvalid = 1'b1; a_out_rready = 1'b1;
        #1;
        tests++; if (a_out_rvalid !== 1'b0) begin fails++; $display("FAIL single_bypass got %b want 0", a_out_rvalid); end
        tick();
        a_in_rvalid = 1'b0;
        tests++; if (a_out_rvalid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", a_out_rvalid); end
        tests++; if (a_out_rid !== 4'd3 || a_out_rdata !== 64'hDEAD_BEEF || a_out_rresp !== 2'd0 || a_out_rlast !== 1'b1) begin
            fails++; $display("FAIL single_payload got %h/%h/%h/%b want 3/deadbeef/0/1", a_out_rid, a_out_rdata, a_out_rresp, a_out_rlast);
        end
        tests++; if (a_count !== 4'd1 || a_bursts !== 4'd1) begin fails++; $display("FAIL single_cnt1 got %0d/%0d want 1/1", a_count, a_bursts); end
        tick();
        tests++; if (a_count !== 4'd0 || a_bursts !== 4'd0 || a_out_rvalid !== 1'b0) begin
            fails++; $display("FAIL single_cnt0 got %0d/%0d v=%b want 0/0 v=0", a_count, a_bursts, a_out_rvalid);
        end
    endtask

    task automatic test_fill();
        int k;
        logic acc;
        k = 0;
        a_out_rready = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (k < 10) drv_a(k, 1'b1, 1'b1);
            else drv_a(0, 1'b0, 1'b0);
            acc = a_in_rready && (k < 10);
            tick();
            if (acc) k++;
        end
        drv_a(0, 1'b0, 1'b0);
        tests++; if (k != 8) begin fails++; $display("FAIL fill_accepted got %0d want 8", k); end
        tests++; if (a_count !== 4'd8 || a_bursts !== 4'd8) begin fails++; $display("FAIL fill_count got %0d/%0d want 8/8", a_count, a_bursts); end
        tests++; if (a_in_rready !== 1'b0) begin fails++; $display("FAIL fill_rready got %b want 0", a_in_rready); end
        a_out_rready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tests++;
            if (a_out_rvalid !== 1'b1 || a_out_rdata !== pd(j) || a_out_rid !== 4'(j) || a_out_rresp !== 2'(j)) begin
                fails++; $display("FAIL fill_drain%0d got v=%b %h want v=1 %h", j, a_out_rvalid, a_out_rdata, pd(j));
            end
            tick();
            if (j == 0) begin
                tests++; if (a_in_rready !== 1'b1) begin fails++; $display("FAIL fill_rready_back got %b want 1", a_in_rready); end
            end
        end
        tests++; if (a_count !== 4'd0 || a_out_rvalid !== 1'b0) begin fails++; $display("FAIL fill_empty got %0d v=%b want 0 v=0", a_count, a_out_rvalid); end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        a_out_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv_a(100 + i, 1'b1, 1'b1);
            tick();
        end
        tests++; if (a_count !== 4'd4) begin fails++; $display("FAIL b2b_prefill got %0d want 4", a_count); end
        a_out_rready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drv_a(104 + c, 1'b1, 1'b1);
            if (a_out_rvalid !== 1'b1 || a_out_rdata !== pd(100 + c)) bad++;
            tick();
            if (a_count !== 4'd4 || a_bursts !== 4'd4) bad++;
        end
        drv_a(0, 1'b0, 1'b0);
        tests++; if (bad != 0) begin fails++; $display("FAIL b2b_stream got %0d errors want 0", bad); end
        for (int j = 0; j < 4; j++) begin
            tests++; if (a_out_rdata !== pd(120 + j)) begin fails++; $display("FAIL b2b_tail%0d got %h want %h", j, a_out_rdata, pd(120 + j)); end
            tick();
        end
        tests++; if (a_count !== 4'd0) begin fails++; $display("FAIL b2b_empty got %0d want 0", a_count); end
    endtask

    task automatic test_store_fwd();
        int bad;
        bad = 0;
        b_out_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv_b(i, i == 3, 1'b1);
            tick();
            drv_b(0, 1'b0, 1'b0);
            if (i < 3) begin
                if (b_out_rvalid !== 1'b0 || b_count !== 4'(i + 1)) bad++;
                tick();
                if (b_out_rvalid !== 1'b0) bad++;
            end
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL sf_gate got %0d early valids want 0", bad); end
        tests++; if (b_out_rvalid !== 1'b1 || b_bursts !== 4'd1) begin fails++; $display("FAIL sf_release got v=%b b=%0d want v=1 b=1", b_out_rvalid, b_bursts); end
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (b_out_rvalid !== 1'b1 || b_out_rdata !== pd(j) || b_out_rlast !== (j == 3)) begin
                fails++; $display("FAIL sf_beat%0d got v=%b %h l=%b want v=1 %h", j, b_out_rvalid, b_out_rdata, b_out_rlast, pd(j));
            end
            tick();
        end
        tests++; if (b_bursts !== 4'd0 || b_count !== 4'd0 || b_out_rvalid !== 1'b0) begin
            fails++; $display("FAIL sf_done got b=%0d c=%0d v=%b want 0/0/0", b_bursts, b_count, b_out_rvalid);
        end
    endtask

    task automatic test_forced_release();
        int k, bad_gate, bad_full;
        logic acc, sawfull;
        logic [63:0] gd[$];
        logic gl[$];
        k = 0; bad_gate = 0; bad_full = 0; sawfull = 1'b0;
        c_out_rready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (k < 6) drv_c(k, k == 5, 1'b1);
            else drv_c(0, 1'b0, 1'b0);
            acc = c_in_rready && (k < 6);
            if (c_count == 3'd4) begin
                sawfull = 1'b1;
                if (c_bursts !== 3'd0) bad_full++;
            end
            if (c_out_rvalid && !sawfull) bad_gate++;
            if (c_out_rvalid) begin gd.push_back(c_out_rdata); gl.push_back(c_out_rlast); end
            tick();
            if (acc) k++;
        end
        drv_c(0, 1'b0, 1'b0);
        tests++; if (!sawfull || bad_full != 0 || bad_gate != 0) begin
            fails++; $display("FAIL fr_fill got full=%b bursts_err=%0d early=%0d want 1/0/0", sawfull, bad_full, bad_gate);
        end
        tests++; if (gd.size() != 6) begin fails++; $display("FAIL fr_count got %0d want 6", gd.size()); end
        for (int j = 0; j < 6; j++) begin
            if (j < gd.size()) begin
                tests++;
                if (gd[j] !== pd(j) || gl[j] !== (j == 5)) begin
                    fails++; $display("FAIL fr_beat%0d got %h l=%b want %h l=%b", j, gd[j], gl[j], pd(j), j == 5);
                end
            end
        end
        drv_c(40, 1'b0, 1'b1);
        tick();
        drv_c(41, 1'b1, 1'b1);
        tests++; if (c_out_rvalid !== 1'b0) begin fails++; $display("FAIL fr_regate got %b want 0", c_out_rvalid); end
        tick();
        drv_c(0, 1'b0, 1'b0);
        tests++; if (c_out_rvalid !== 1'b1 || c_out_rdata !== pd(40)) begin
            fails++; $display("FAIL fr_next got v=%b %h want v=1 %h", c_out_rvalid, c_out_rdata, pd(40));
        end
        tick();
        tests++; if (c_out_rdata !== pd(41) || c_out_rlast !== 1'b1) begin fails++; $display("FAIL fr_next2 got %h want %h", c_out_rdata, pd(41)); end
        tick();
        tests++; if (c_count !== 3'd0 || c_bursts !== 3'd0) begin fails++; $display("FAIL fr_empty got %0d/%0d want 0/0", c_count, c_bursts); end
    endtask

    task automatic test_async_reset();
        a_out_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drv_a(200 + i, (i == 2) || (i == 4), 1'b1);
            tick();
        end
        drv_a(0, 1'b0, 1'b0);
        tests++; if (a_count !== 4'd5 || a_bursts !== 4'd2) begin fails++; $display("FAIL ar_pre got %0d/%0d want 5/2", a_count, a_bursts); end
        #2;
        arstn = 1'b0;
        #1;
        tests++; if (a_out_rvalid !== 1'b0 || a_count !== 4'd0 || a_bursts !== 4'd0) begin
            fails++; $display("FAIL ar_immediate got v=%b %0d/%0d want 0 0/0", a_out_rvalid, a_count, a_bursts);
        end
        tests++; if (a_in_rready !== 1'b0) begin fails++; $display("FAIL ar_rready got %b want 0", a_in_rready); end
        tick();
        arstn = 1'b1;
        #1;
        tests++; if (a_in_rready !== 1'b1) begin fails++; $display("FAIL ar_release got %b want 1", a_in_rready); end
        drv_a(9, 1'b1, 1'b1);
        a_out_rready = 1'b1;
        tick();
        drv_a(0, 1'b0, 1'b0);
        tests++; if (a_out_rvalid !== 1'b1 || a_out_rdata !== pd(9) || a_out_rid !== 4'd9) begin
            fails++; $display("FAIL ar_roundtrip got v=%b %h want v=1 %h", a_out_rvalid, a_out_rdata, pd(9));
        end
        tick();
        tests++; if (a_count !== 4'd0) begin fails++; $display("FAIL ar_final got %0d want 0", a_count); end
    endtask

    initial begin
        drv_a(0, 1'b0, 1'b0); a_out_rready = 1'b0;
        drv_b(0, 1'b0, 1'b0); b_out_rready = 1'b0;
        drv_c(0, 1'b0, 1'b0); c_out_rready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_store_fwd();
        test_forced_release();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
